// File: rtl/rsa_cmd_pkg.sv
// Shared opcodes, FSM encoding, error codes and command field layout
// for the ARM-facing RSA command bank.
package rsa_cmd_pkg;

    localparam logic [7:0] OP_LOAD    = 8'h00;
    localparam logic [7:0] OP_COMPUTE = 8'h01;
    localparam logic [7:0] OP_STORE   = 8'h02;
    localparam logic [7:0] OP_CLEAR   = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CMD     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int OP_LSB   = 24;
    localparam int DST_LSB  = 16;
    localparam int SRCA_LSB = 8;
    localparam int SRCB_LSB = 0;
    localparam int FIELD_W  = 8;

    // Full 8-bit field compare, so stray bits above the index width fail too.
    function automatic logic idx_ok(input logic [FIELD_W-1:0] f, input int n);
        return 32'(f) < 32'(n);
    endfunction

endpackage

// File: rtl/rsa_reg_bank.sv
// Operand storage: one write port, synchronous clear-all,
// three combinational read ports.
module rsa_reg_bank
    import rsa_cmd_pkg::*;
#(
    parameter int DATA_W   = 1024,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ra_idx,
    input  logic [IDX_W-1:0]  rb_idx,
    input  logic [IDX_W-1:0]  rs_idx,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] rs_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = mem[ra_idx];
    assign rb_data = mem[rb_idx];
    assign rs_data = mem[rs_idx];

endmodule

// File: rtl/rsa_cmd_bank.sv
// ARM command decoder and sequencer around a bank of RSA operand
// registers and an external start/done modular-arithmetic core.
module rsa_cmd_bank
    import rsa_cmd_pkg::*;
#(
    parameter int DATA_W   = 1024,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int TIMEOUT  = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    output logic [1:0]        fpga_to_arm_err,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic              accel_start,
    output logic              accel_abort,
    output logic [DATA_W-1:0] accel_op_a,
    output logic [DATA_W-1:0] accel_op_b,
    input  logic              accel_done,
    input  logic [DATA_W-1:0] accel_result,
    output logic [3:0]        leds
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             state_q;
    logic [1:0]         err_q;
    logic               abort_q;
    logic [IDX_W-1:0]   dst_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  op_a_q;
    logic [DATA_W-1:0]  op_b_q;
    logic [DATA_W-1:0]  out_q;

    logic [FIELD_W-1:0] f_op;
    logic [FIELD_W-1:0] f_dst;
    logic [FIELD_W-1:0] f_a;
    logic [FIELD_W-1:0] f_b;
    logic               cmd_bad;
    logic               accept;
    logic               clr;
    logic               load_xfer;
    logic               acc_hit;
    logic               we;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  ra_data;
    logic [DATA_W-1:0]  rb_data;
    logic [DATA_W-1:0]  rs_data;

    assign f_op  = arm_to_fpga_cmd[OP_LSB   +: FIELD_W];
    assign f_dst = arm_to_fpga_cmd[DST_LSB  +: FIELD_W];
    assign f_a   = arm_to_fpga_cmd[SRCA_LSB +: FIELD_W];
    assign f_b   = arm_to_fpga_cmd[SRCB_LSB +: FIELD_W];

    always_comb begin
        cmd_bad = 1'b0;
        unique case (f_op)
            OP_LOAD:    cmd_bad = !idx_ok(f_dst, NUM_REGS);
            OP_COMPUTE: cmd_bad = !(idx_ok(f_dst, NUM_REGS) &&
                                    idx_ok(f_a, NUM_REGS) &&
                                    idx_ok(f_b, NUM_REGS));
            OP_STORE:   cmd_bad = !idx_ok(f_a, NUM_REGS);
            OP_CLEAR:   cmd_bad = 1'b0;
            default:    cmd_bad = 1'b1;
        endcase
    end

    assign accept    = (state_q == ST_IDLE) && arm_to_fpga_cmd_valid;
    assign clr       = accept && !cmd_bad && (f_op == OP_CLEAR);
    assign load_xfer = (state_q == ST_LOAD) && arm_to_fpga_data_valid;
    assign acc_hit   = (state_q == ST_WAIT) && accel_done;
    assign we        = load_xfer || acc_hit;
    assign wdata     = acc_hit ? accel_result : arm_to_fpga_data;

    // Read ports follow the incoming command so operands and store data
    // can be captured on the accepting edge itself.
    rsa_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .we      (we),
        .waddr   (dst_q),
        .wdata   (wdata),
        .ra_idx  (f_a[IDX_W-1:0]),
        .rb_idx  (f_b[IDX_W-1:0]),
        .rs_idx  (f_a[IDX_W-1:0]),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .rs_data (rs_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_OK;
            abort_q <= 1'b0;
            dst_q   <= '0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            out_q   <= '0;
        end else begin
            abort_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arm_to_fpga_cmd_valid) begin
                        dst_q <= f_dst[IDX_W-1:0];
                        if (cmd_bad) begin
                            err_q   <= ERR_CMD;
                            state_q <= ST_DONE;
                        end else begin
                            unique case (f_op)
                                OP_LOAD: state_q <= ST_LOAD;
                                OP_COMPUTE: begin
                                    op_a_q  <= ra_data;
                                    op_b_q  <= rb_data;
                                    state_q <= ST_START;
                                end
                                OP_STORE: begin
                                    out_q   <= rs_data;
                                    state_q <= ST_STORE;
                                end
                                default: state_q <= ST_DONE;
                            endcase
                        end
                    end
                end
                ST_LOAD: begin
                    if (arm_to_fpga_data_valid) state_q <= ST_DONE;
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the final cycle still wins.
                    if (accel_done) begin
                        err_q   <= ERR_OK;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        abort_q <= 1'b1;
                        err_q   <= ERR_TIMEOUT;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STORE: begin
                    if (fpga_to_arm_data_ready) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (fpga_to_arm_done_read) begin
                        err_q   <= ERR_OK;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fpga_to_arm_done       = (state_q == ST_DONE);
    assign fpga_to_arm_err        = err_q;
    assign arm_to_fpga_data_ready = (state_q == ST_LOAD);
    assign fpga_to_arm_data_valid = (state_q == ST_STORE);
    assign fpga_to_arm_data       = out_q;
    assign accel_start            = (state_q == ST_START);
    assign accel_abort            = abort_q;
    assign accel_op_a             = op_a_q;
    assign accel_op_b             = op_b_q;
    assign leds                   = {err_q != ERR_OK, state_q};

endmodule

// File: doc/rsa_cmd_bank.md
# rsa_cmd_bank

Parametrised successor to the single-register ARM/FPGA command wrapper. It holds a bank of `NUM_REGS` operand registers, each `DATA_W` bits wide. It decodes 32-bit ARM commands that carry register indices, and launches an external modular-arithmetic core through a start/done handshake guarded by a timeout. The block sits between the PS-side command/data ports and the RSA datapath, and reports per-command error status.

## Interface
- `DATA_W`, 1024, width of each operand register and of the data ports
- `NUM_REGS`, 4, number of operand registers (2..256)
- `IDX_W`, $clog2(NUM_REGS), width of a register index
- `TIMEOUT`, 65536, maximum WAIT cycles before the compute is aborted (≥2)
- `clk` in 1 — single clock, all logic rising-edge
- `reset` in 1 — asynchronous, active-high; clears every register and output
- `arm_to_fpga_cmd` in 32 — command word: [31:24] opcode, [23:16] dst, [15:8] srcA, [7:0] srcB
- `arm_to_fpga_cmd_valid` in 1 — command present; sampled only in IDLE
- `fpga_to_arm_done` out 1 — command finished; held until acknowledged
- `fpga_to_arm_err` out 2 — 0 OK, 1 bad command, 2 timeout; valid while done=1
- `fpga_to_arm_done_read` in 1 — ARM acknowledges done
- `arm_to_fpga_data_valid` in 1 / `arm_to_fpga_data_ready` out 1 / `arm_to_fpga_data` in DATA_W — inbound data
- `fpga_to_arm_data_valid` out 1 / `fpga_to_arm_data_ready` in 1 / `fpga_to_arm_data` out DATA_W — outbound data
- `accel_start` out 1 — one-cycle launch pulse
- `accel_abort` out 1 — one-cycle pulse on timeout
- `accel_op_a`, `accel_op_b` out DATA_W — operands, stable from START until leaving WAIT
- `accel_done` in 1 — result valid pulse / `accel_result` in DATA_W
- `leds` out 4 — {err!=0, state[2:0]}

## Operation
- Opcodes:
  - 0x00 LOAD: receive ARM data into reg[dst].
  - 0x01 COMPUTE: run the core with reg[srcA] and reg[srcB]; write the result to reg[dst].
  - 0x02 STORE: send reg[srcA] to the ARM.
  - 0x03 CLEAR: zero all registers.
- Bad command: any other opcode, or any used index ≥ NUM_REGS. Transition IDLE→DONE with err=1; no register changes.
- States:
  - IDLE: on cmd_valid, decode → LOAD_S / START / STORE_S / DONE. CLEAR goes directly to DONE and zeroes all registers on that edge.
  - LOAD_S: data_ready=1. On valid&&ready, write reg[dst] and go to DONE.
  - START: accel_start=1, latch operands, clear timeout counter, go to WAIT.
  - WAIT: counter increments each cycle. On accel_done, write accel_result to reg[dst] and go to DONE with err=0. When the counter reaches TIMEOUT-1 without done, pulse accel_abort, go to DONE with err=2, dst unchanged. If accel_done and the timeout coincide, done wins.
  - STORE_S: fpga_to_arm_data is loaded from reg[srcA] on the IDLE→STORE_S edge; data_valid=1. On valid&&ready, go to DONE.
  - DONE: done=1; on done_read, clear err and go to IDLE.
- Decoded dst/srcA/srcB are latched at command acceptance. cmd_valid outside IDLE is ignored.
- accel_done outside WAIT is ignored.
- Unused index bits above IDX_W must be zero, otherwise err=1.

## Timing
- Reset values: all outputs 0; state IDLE; registers, operands and fpga_to_arm_data 0. Assertion mid-operation aborts immediately with no abort pulse.
- All outputs are decoded from registered state or are registers; there is no combinational input→output path.
- LOAD: cmd edge t → ready=1 from t+1 → transfer at edge t+k → done=1 from t+k+1.
- COMPUTE: cmd edge t → accel_start high during cycle t+1 → WAIT from t+2 → accel_done at edge u → done from u+1.
- Timeout: done at exactly TIMEOUT cycles after entering WAIT.
- Bad command and CLEAR: done=1 one cycle after the accepting edge.
- done_read takes effect only in DONE. The earliest next command is accepted one cycle after returning to IDLE.

## Structure
- Package `rsa_cmd_pkg` holds:
  - opcode localparams
  - state encoding (3-bit)
  - error codes
  - the command field bit positions
- Sub-module `rsa_reg_bank` holds NUM_REGS×DATA_W storage with one write port, synchronous clear-all and three combinational read ports (srcA, srcB, store).
- The top level holds the FSM, index latches, timeout counter and output registers.

## Test plan
- Reset held, then released: every output is 0 and leds=0. A STORE of reg0 returns 0.
- LOAD dst=1 with data 0xA5…A5, then STORE srcA=1: returns 0xA5…A5, err=0. STORE srcA=0 still returns 0.
- LOAD reg0=7 and reg1=9. COMPUTE dst=2 srcA=0 srcB=1 with a model returning a+b after 5 cycles: exactly one accel_start, op_a=7, op_b=9, done with err=0. STORE reg2 returns 16.
- TIMEOUT=16 with a model that never asserts done: accel_abort pulses once, done with err=2 exactly 16 cycles after WAIT entry, reg[dst] unchanged.
- Opcode 0x07, then LOAD dst=4 with NUM_REGS=4: done with err=1 one cycle later, data_ready never asserted, registers unchanged.
- Reset mid-WAIT, and cmd_valid pulses during DONE: outputs clear asynchronously, registers read 0 afterwards, and pulses during DONE cause no state change.
